// File: rtl/sync_fifo_param_pkg.sv
// Shared types for the parametrised single-clock FIFO.
// The request encoding lets the occupancy update read as a decode of what happened this cycle.
package sync_fifo_param_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WR    = 2'b01,
        OP_RD    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_defs.vh
// Helper function and elaboration-time parameter range checks, included inside sync_fifo_param.
// The checks are simulation-only and do not synthesise.
function automatic int fifo_clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
        r++;
        v = v >> 1;
    end
    return r;
endfunction

`ifndef SYNTHESIS
localparam bit FIFO_PARAMS_OK = (DATA_W >= 1) && (ADDR_W >= 1) &&
                                (AF_THRESH >= 1) && (AF_THRESH <= DEPTH) &&
                                (AE_THRESH >= 0) && (AE_THRESH <= DEPTH - 1) &&
                                (fifo_clog2(DEPTH + 1) == ADDR_W + 1);

always @(posedge clk) begin
    assert (FIFO_PARAMS_OK) else $error("sync_fifo_param: parameter out of range");
end
`endif

// File: rtl/sdp_ram_param.sv
// Simple dual-port RAM, one write port and one synchronous-read port, no reset so it maps to block RAM.
// Read data appears one cycle after re and holds while re is low.
module sdp_ram_param #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, almost flags, sticky errors and flush; 1-cycle read latency.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; over-write/over-read are dropped and flagged.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 12,
    parameter int AF_THRESH = (2**ADDR_W) - 4,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    `include "fifo_defs.vh"

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic              ovf_q;
    logic              udf_q;
    logic              dout_loaded;
    logic [DATA_W-1:0] ram_q;
    logic              wr_acc;
    logic              rd_acc;
    logic              ram_we;
    logic              ram_re;
    fifo_op_e          op;

    assign full   = (count_q == DEPTH_C);
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;
    assign ram_we = wr_acc & ~clr;

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM output register doubles as the prefetch stage; head_vld marks it as holding the head word.
    logic head_vld;
    logic mem_has;

    assign empty   = ~head_vld;
    assign mem_has = head_vld ? (count_q > CNT_W'(1)) : (count_q != '0);
    assign ram_re  = ~clr & mem_has & (~head_vld | rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_vld <= 1'b0;
        end else if (clr) begin
            head_vld <= 1'b0;
        end else if (ram_re) begin
            head_vld <= 1'b1;
        end else if (rd_acc) begin
            head_vld <= 1'b0;
        end
    end
`else
    assign empty  = (count_q == '0);
    assign ram_re = rd_acc & ~clr;
`endif

    always_comb begin
        op        = fifo_op_e'({rd_acc, wr_acc});
        count_nxt = count_q;
        case (op)
            OP_WR:   count_nxt = count_q + 1'b1;
            OP_RD:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt;
            if (wr_en & full) begin
                ovf_q <= 1'b1;
            end
            if (rd_en & empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    // The RAM register has no reset; dout reads zero until the first word is ever loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_loaded <= 1'b0;
        end else if (ram_re) begin
            dout_loaded <= 1'b1;
        end
    end

    sdp_ram_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    assign dout         = dout_loaded ? ram_q : '0;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=12, ADDR_W=4, AF=14, AE=2); standard build unless SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [11:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [11:0] dout;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int vectors = 0;
    int miscompares = 0;

    sync_fifo_param #(
        .DATA_W    (12),
        .ADDR_W    (4),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae got %b want 1", almost_empty); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af got %b want 0", almost_full); end
        vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL reset_err got ovf=%b udf=%b want 0 0", overflow, underflow); end
        vectors++; if (dout !== 12'h000) begin miscompares++; $display("FAIL reset_dout got %h want 000", dout); end
    endtask

`ifndef SYNC_FIFO_FWFT_EN
    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            din = 12'(i); wr_en = 1'b1;
            tick();
            vectors++; if (count !== 5'(i)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
            vectors++; if (almost_full !== (i >= 14)) begin miscompares++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i >= 14)); end
            vectors++; if (almost_empty !== (i <= 2)) begin miscompares++; $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, (i <= 2)); end
            vectors++; if (full !== (i == 16)) begin miscompares++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 16)); end
        end
        din = 12'h011;
        tick();
        wr_en = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fill_overflow got %b want 1", overflow); end
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_ovf_count got %0d want 16", count); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            tick();
            vectors++; if (dout !== 12'(i)) begin miscompares++; $display("FAIL drain_dout[%0d] got %h want %h", i, dout, 12'(i)); end
            vectors++; if (count !== 5'(16 - i)) begin miscompares++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 16 - i); end
            vectors++; if (empty !== (i == 16)) begin miscompares++; $display("FAIL drain_empty[%0d] got %b want %b", i, empty, (i == 16)); end
        end
        tick();
        rd_en = 1'b0;
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL drain_underflow got %b want 1", underflow); end
        vectors++; if (dout !== 12'h010) begin miscompares++; $display("FAIL drain_hold got %h want 010", dout); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            din = 12'h100 + 12'(k); wr_en = 1'b1;
            tick();
        end
        vectors++; if (count !== 5'd8) begin miscompares++; $display("FAIL b2b_prefill got %0d want 8", count); end
        rd_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            din = 12'h108 + 12'(c);
            tick();
            vectors++; if (dout !== 12'h100 + 12'(c)) begin miscompares++; $display("FAIL b2b_dout[%0d] got %h want %h", c, dout, 12'h100 + 12'(c)); end
            vectors++; if (count !== 5'd8) begin miscompares++; $display("FAIL b2b_count[%0d] got %0d want 8", c, count); end
        end
        wr_en = 1'b0;
        for (int c = 20; c < 28; c++) begin
            tick();
            vectors++; if (dout !== 12'h100 + 12'(c)) begin miscompares++; $display("FAIL b2b_tail[%0d] got %h want %h", c, dout, 12'h100 + 12'(c)); end
        end
        rd_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty got %b want 1", empty); end
    endtask

    task automatic test_full_both();
        for (int k = 0; k < 16; k++) begin
            din = 12'h200 + 12'(k); wr_en = 1'b1;
            tick();
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fb_full got %b want 1", full); end
        din = 12'h2FF; rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        vectors++; if (count !== 5'd15) begin miscompares++; $display("FAIL fb_count got %0d want 15", count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fb_overflow got %b want 1", overflow); end
        vectors++; if (dout !== 12'h200) begin miscompares++; $display("FAIL fb_dout got %h want 200", dout); end
        for (int k = 1; k < 16; k++) begin
            tick();
            vectors++; if (dout !== 12'h200 + 12'(k)) begin miscompares++; $display("FAIL fb_drain[%0d] got %h want %h", k, dout, 12'h200 + 12'(k)); end
        end
        rd_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fb_empty got %b want 1", empty); end
    endtask

    task automatic test_clr();
        for (int k = 1; k <= 5; k++) begin
            din = 12'h300 + 12'(k); wr_en = 1'b1;
            tick();
        end
        vectors++; if (count !== 5'd5 || overflow !== 1'b1) begin miscompares++; $display("FAIL clr_pre got count=%0d ovf=%b want 5 1", count, overflow); end
        clr = 1'b1; din = 12'h3AA;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL clr_count got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL clr_empty got %b want 1", empty); end
        vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL clr_err got ovf=%b udf=%b want 0 0", overflow, underflow); end
        vectors++; if (dout !== 12'h20F) begin miscompares++; $display("FAIL clr_dout_hold got %h want 20f", dout); end
        din = 12'h3BB; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (dout !== 12'h3BB) begin miscompares++; $display("FAIL clr_reuse got %h want 3bb", dout); end
    endtask

    task automatic test_rst_mid();
        din = 12'h401; wr_en = 1'b1;
        tick();
        din = 12'h402;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", count); end
        vectors++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty got e=%b ae=%b want 1 1", empty, almost_empty); end
        vectors++; if (dout !== 12'h000) begin miscompares++; $display("FAIL rst_dout got %h want 000", dout); end
        wr_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (count !== 5'd0 || full !== 1'b0) begin miscompares++; $display("FAIL rst_after got count=%0d full=%b want 0 0", count, full); end
    endtask
`else
    task automatic test_fwft();
        din = 12'h0AB; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fwft_empty_k got %b want 1", empty); end
        tick();
        vectors++; if (dout !== 12'h0AB) begin miscompares++; $display("FAIL fwft_dout got %h want 0ab", dout); end
        vectors++; if (empty !== 1'b0 || count !== 5'd1) begin miscompares++; $display("FAIL fwft_head got e=%b count=%0d want 0 1", empty, count); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (empty !== 1'b1 || count !== 5'd0) begin miscompares++; $display("FAIL fwft_pop got e=%b count=%0d want 1 0", empty, count); end
        for (int k = 1; k <= 3; k++) begin
            din = 12'h0C0 + 12'(k); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        tick();
        rd_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            vectors++; if (dout !== 12'h0C0 + 12'(k)) begin miscompares++; $display("FAIL fwft_seq[%0d] got %h want %h", k, dout, 12'h0C0 + 12'(k)); end
            tick();
        end
        rd_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fwft_end got %b want 1", empty); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef SYNC_FIFO_FWFT_EN
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_both();
        test_clr();
        test_rst_mid();
`else
        test_fwft();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
